m68k_bus_initiator: RTL and testbench
=====================================

// Module: m68k_bus_initiator
// PURPOSE
//  Bus-master end of the 68000 asynchronous bus protocol: drives A/AS/UDS/LDS/RW and completes
//  on DTACK, BERR or timeout. Counterpart to the glue logic that decodes AS/UDS/LDS and returns
//  DTACK. Used by the on-FPGA DMA/test engine to access SRAM/PROM space while the CPU is held off
//  the bus. Bus-side strobes and acknowledges are active-low; the user-side handshake is active-high.
// PARAMETERS
//  TIMEOUT_CYCLES  64  WAIT cycles without DTACK/BERR before a forced error completion (>=2)
//  SYNC_STAGES     2   flip-flop depth of the DTACK/BERR input synchronizers (>=2)
// PORTS
//  CPUCLK_IN  in   1   sole clock, all logic on rising edge
//  RESET      in   1   synchronous, active-high reset
//  REQ        in   1   start a cycle; sampled only in IDLE
//  WR         in   1   1=write, 0=read (latched with REQ)
//  BE         in   2   byte enables, [1]=upper(UDS) [0]=lower(LDS); latched with REQ
//  ADDR_IN    in   23  word address A[23:1]; latched with REQ
//  WDATA      in   16  write data; latched with REQ
//  BUSY       out  1   high from the accepting edge until return to IDLE
//  DONE       out  1   one-cycle completion pulse
//  ERR        out  1   valid with DONE: 1 = BERR or timeout
//  RDATA      out  16  read data, captured at read completion
//  A          out  23  bus address
//  D_OUT      out  16  bus write data;  D_OE out 1: drive D_OUT onto bus (writes only)
//  D_IN       in   16  bus read data
//  AS,UDS,LDS out  1   active-low strobes;  RW out 1: 1=read, 0=write
//  DTACK,BERR in   1   active-low, asynchronous; synchronized before use
// BEHAVIOUR
//  - All outputs registered. Reset: AS=UDS=LDS=RW=1, D_OE=0, BUSY=DONE=ERR=0, A=0, D_OUT=0,
//    RDATA=0, state IDLE, timeout counter 0, synchronizers preset to 1 (negated).
//  - IDLE: REQ=1 with BE!=0 -> latch WR/BE/ADDR_IN/WDATA, BUSY=1, A/RW/D_OUT/D_OE driven, -> ADDR.
//    REQ with BE==0 is ignored (no cycle, no DONE). REQ outside IDLE ignored.
//  - ADDR (1 cycle, address setup): AS still 1 -> STROBE. Edge: AS=0; reads also assert
//    UDS=~BE[1], LDS=~BE[0] on this edge.
//  - STROBE: reads -> WAIT; writes -> DSTROBE (data strobes asserted on the following edge) -> WAIT.
//  - WAIT: counter increments each cycle. Priority on synchronized inputs: BERR low > DTACK low >
//    timeout. DTACK: read captures D_IN into RDATA; DONE=1,ERR=0. BERR or count==TIMEOUT_CYCLES-1:
//    DONE=1,ERR=1, RDATA unchanged. On that same edge AS/UDS/LDS->1, D_OE->0, -> RECOVER.
//  - RECOVER: hold strobes negated until both synchronized DTACK and BERR are 1, then RW->1,
//    BUSY->0, -> IDLE. Not timed. Earliest next acceptance is the cycle after BUSY falls.
//  - DONE/ERR high exactly one cycle. A/D_OUT stable from ADDR through RECOVER.
//  - RESET mid-cycle: strobes negate and D_OE drops on the reset edge; no DONE issued.
//  - Latency (SYNC_STAGES=2, DTACK low combinationally with the data strobes): DONE on the 4th
//    edge after the accepting edge for reads, 5th for writes.
// STRUCTURE
//  - Shared package m68k_bus_pkg: state encoding (IDLE, ADDR, STROBE, DSTROBE, WAIT, RECOVER),
//    address/data width constants, BE_UPPER/BE_LOWER bit indices.
//  - Sub-module sync_ff (WIDTH, STAGES, RESET_VAL) instantiated for {DTACK,BERR}.
//  - One FSM plus timeout counter (width $clog2(TIMEOUT_CYCLES)+1) in this module.
// TESTING (responder model: DTACK = ~(~AS & (~UDS | ~LDS)), BERR=1 unless stated)
//  - Word read A=0x000100, BE=11, D_IN=0xBEEF -> UDS=LDS=0 with AS; DONE on edge 4, ERR=0,
//    RDATA=0xBEEF; BUSY falls after DTACK negates.
//  - Byte write BE=10, WDATA=0x12AB -> AS low one cycle before UDS, LDS stays 1, RW=0, D_OE=1;
//    DONE on edge 5, ERR=0.
//  - DTACK tied 1 -> DONE,ERR=1 after exactly TIMEOUT_CYCLES WAIT cycles; strobes negated.
//  - BERR and DTACK asserted on the same edge during WAIT -> ERR=1, RDATA unchanged.
//  - RESET asserted while in WAIT -> next edge AS=UDS=LDS=1, D_OE=0, BUSY=0, no DONE;
//    REQ with BE=00 -> no bus activity.
//  - Back-to-back REQ held high -> second cycle starts only after RECOVER; AS high >=2 cycles between.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus-master initiator: widths, byte-lane indices and FSM encoding.
package m68k_bus_pkg;

  localparam int ADDR_W   = 23;
  localparam int DATA_W   = 16;
  localparam int BE_W     = 2;
  localparam int BE_UPPER = 1;
  localparam int BE_LOWER = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STROBE,
    ST_DSTROBE,
    ST_WAIT,
    ST_RECOVER
  } state_t;

  // Active-low {UDS, LDS} for a set of byte enables.
  function automatic logic [1:0] data_strobes_n(input logic [BE_W-1:0] be);
    return {~be[BE_UPPER], ~be[BE_LOWER]};
  endfunction

endpackage

// File: rtl/m68k_bus_initiator_sync_ff.sv
// Multi-stage flip-flop synchronizer for asynchronous bus inputs, with a configurable reset value.
module sync_ff #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value
  // of its predecessor; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000 asynchronous bus master: runs one read/write cycle per request and completes on
// DTACK, BERR or timeout, then waits for the responder to release before going idle.
module m68k_bus_initiator
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              CPUCLK_IN,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              WR,
  input  logic [BE_W-1:0]   BE,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] RDATA,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_OE,
  input  logic [DATA_W-1:0] D_IN,
  output logic              AS,
  output logic              UDS,
  output logic              LDS,
  output logic              RW,
  input  logic              DTACK,
  input  logic              BERR
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] a_d;
  logic [DATA_W-1:0] d_out_d, rdata_d;
  logic              d_oe_d, as_d, uds_d, lds_d, rw_d, busy_d, done_d, err_d;
  logic              dtack_s, berr_s;

  sync_ff #(
    .WIDTH    (2),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(2'b11)
  ) u_sync (
    .clk  (CPUCLK_IN),
    .reset(RESET),
    .d    ({DTACK, BERR}),
    .q    ({dtack_s, berr_s})
  );

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      A       <= '0;
      D_OUT   <= '0;
      D_OE    <= 1'b0;
      AS      <= 1'b1;
      UDS     <= 1'b1;
      LDS     <= 1'b1;
      RW      <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      A       <= a_d;
      D_OUT   <= d_out_d;
      D_OE    <= d_oe_d;
      AS      <= as_d;
      UDS     <= uds_d;
      LDS     <= lds_d;
      RW      <= rw_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      ERR     <= err_d;
      RDATA   <= rdata_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path leaves one unassigned and
  // no latch is inferred; registered outputs default to holding their current value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    be_d    = be_q;
    a_d     = A;
    d_out_d = D_OUT;
    d_oe_d  = D_OE;
    as_d    = AS;
    uds_d   = UDS;
    lds_d   = LDS;
    rw_d    = RW;
    busy_d  = BUSY;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = RDATA;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ && (BE != '0)) begin
          wr_d    = WR;
          be_d    = BE;
          a_d     = ADDR_IN;
          d_out_d = WDATA;
          d_oe_d  = WR;
          rw_d    = ~WR;
          busy_d  = 1'b1;
          state_d = ST_ADDR;
        end
      end

      // Reads may strobe data with AS; writes hold data strobes one more cycle for data setup.
      ST_ADDR: begin
        as_d = 1'b0;
        if (!wr_q) {uds_d, lds_d} = data_strobes_n(be_q);
        state_d = ST_STROBE;
      end

      ST_STROBE: begin
        cnt_d = '0;
        if (wr_q) begin
          {uds_d, lds_d} = data_strobes_n(be_q);
          state_d = ST_DSTROBE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_DSTROBE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!berr_s || !dtack_s || (cnt_q == CNT_LAST)) begin
          done_d  = 1'b1;
          err_d   = !berr_s || dtack_s;
          if (berr_s && !dtack_s && !wr_q) rdata_d = D_IN;
          as_d    = 1'b1;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
          d_oe_d  = 1'b0;
          state_d = ST_RECOVER;
        end
      end

      // Wait for the responder to negate both acknowledges before releasing the bus.
      ST_RECOVER: begin
        if (dtack_s && berr_s) begin
          rw_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator with a combinational DTACK responder on the bus side.
module tb_m68k_bus_initiator;

  logic        CPUCLK_IN = 1'b0;
  logic        RESET, REQ, WR;
  logic [1:0]  BE;
  logic [22:0] ADDR_IN;
  logic [15:0] WDATA, D_IN;
  logic        BUSY, DONE, ERR, D_OE, AS, UDS, LDS, RW, DTACK, BERR;
  logic [15:0] RDATA, D_OUT;
  logic [22:0] A;
  logic        dtack_tie;

  int checks = 0;
  int errors = 0;

  always #5 CPUCLK_IN = ~CPUCLK_IN;

  // Responder: acknowledge whenever AS and at least one data strobe are asserted.
  assign DTACK = dtack_tie | ~(~AS & (~UDS | ~LDS));

  m68k_bus_initiator #(
    .TIMEOUT_CYCLES(64),
    .SYNC_STAGES   (2)
  ) dut (
    .CPUCLK_IN(CPUCLK_IN),
    .RESET    (RESET),
    .REQ      (REQ),
    .WR       (WR),
    .BE       (BE),
    .ADDR_IN  (ADDR_IN),
    .WDATA    (WDATA),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .RDATA    (RDATA),
    .A        (A),
    .D_OUT    (D_OUT),
    .D_OE     (D_OE),
    .D_IN     (D_IN),
    .AS       (AS),
    .UDS      (UDS),
    .LDS      (LDS),
    .RW       (RW),
    .DTACK    (DTACK),
    .BERR     (BERR)
  );

  task automatic cyc();
    @(posedge CPUCLK_IN);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int early_done, idle_busy, idle_as;
    int first_fall, second_fall, done1, done_cnt;
    logic prev_as;

    RESET = 1'b1; REQ = 1'b0; WR = 1'b0; BE = 2'b00; ADDR_IN = '0; WDATA = '0;
    D_IN = '0; BERR = 1'b1; dtack_tie = 1'b0;
    cyc(); cyc();
    check("rst_as",   AS,   1);
    check("rst_uds",  UDS,  1);
    check("rst_lds",  LDS,  1);
    check("rst_rw",   RW,   1);
    check("rst_doe",  D_OE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err",  ERR,  0);
    check("rst_a",    A,    0);
    check("rst_rdata", RDATA, 0);
    RESET = 1'b0;
    cyc();

    // Word read: DONE on edge 4, BUSY falls on edge 7.
    REQ = 1'b1; WR = 1'b0; BE = 2'b11; ADDR_IN = 23'h000100; D_IN = 16'hBEEF;
    cyc();
    REQ = 1'b0;
    check("rd_busy0", BUSY, 1);
    check("rd_a",     A,    32'h100);
    check("rd_rw",    RW,   1);
    check("rd_doe",   D_OE, 0);
    check("rd_as0",   AS,   1);
    cyc();
    check("rd_as1",  AS,  0);
    check("rd_uds1", UDS, 0);
    check("rd_lds1", LDS, 0);
    cyc();
    check("rd_done2", DONE, 0);
    cyc();
    check("rd_done3", DONE, 0);
    cyc();
    check("rd_done4", DONE, 1);
    check("rd_err4",  ERR,  0);
    check("rd_data",  RDATA, 32'hBEEF);
    check("rd_as4",   AS,   1);
    check("rd_uds4",  UDS,  1);
    cyc();
    check("rd_done5", DONE, 0);
    check("rd_busy5", BUSY, 1);
    cyc();
    check("rd_busy6", BUSY, 1);
    cyc();
    check("rd_busy7", BUSY, 0);

    // Upper-byte write: AS one cycle before UDS, DONE on edge 5.
    REQ = 1'b1; WR = 1'b1; BE = 2'b10; ADDR_IN = 23'h2A5A5; WDATA = 16'h12AB;
    cyc();
    REQ = 1'b0;
    check("wr_rw",   RW,    0);
    check("wr_doe",  D_OE,  1);
    check("wr_dout", D_OUT, 32'h12AB);
    check("wr_a",    A,     32'h2A5A5);
    cyc();
    check("wr_as1",  AS,  0);
    check("wr_uds1", UDS, 1);
    check("wr_lds1", LDS, 1);
    cyc();
    check("wr_uds2", UDS, 0);
    check("wr_lds2", LDS, 1);
    cyc();
    check("wr_done3", DONE, 0);
    cyc();
    check("wr_done4", DONE, 0);
    cyc();
    check("wr_done5", DONE, 1);
    check("wr_err5",  ERR,  0);
    check("wr_doe5",  D_OE, 0);
    check("wr_rdata", RDATA, 32'hBEEF);
    cyc(); cyc(); cyc();
    check("wr_busy8", BUSY, 0);
    check("wr_rw8",   RW,   1);

    // Timeout: DTACK never asserts; WAIT entered on edge 2, 64 WAIT cycles -> DONE on edge 66.
    dtack_tie = 1'b1; D_IN = 16'h5555;
    REQ = 1'b1; WR = 1'b0; BE = 2'b01; ADDR_IN = 23'h7FFFFF;
    cyc();
    REQ = 1'b0;
    check("to_busy0", BUSY, 1);
    cyc();
    check("to_uds1", UDS, 1);
    check("to_lds1", LDS, 0);
    early_done = 0;
    for (int i = 2; i <= 65; i++) begin
      cyc();
      if (DONE) early_done = 1;
    end
    check("to_early", early_done, 0);
    cyc();
    check("to_done",  DONE, 1);
    check("to_err",   ERR,  1);
    check("to_as",    AS,   1);
    check("to_lds",   LDS,  1);
    check("to_rdata", RDATA, 32'hBEEF);
    cyc();
    check("to_done67", DONE, 0);
    check("to_busy67", BUSY, 0);

    // BERR and DTACK together in WAIT: error wins, RDATA untouched.
    D_IN = 16'h1234;
    REQ = 1'b1; WR = 1'b0; BE = 2'b11; ADDR_IN = 23'h000200;
    cyc();
    REQ = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    dtack_tie = 1'b0; BERR = 1'b0;
    cyc();
    cyc();
    check("be_done6", DONE, 0);
    cyc();
    check("be_done7", DONE, 1);
    check("be_err7",  ERR,  1);
    check("be_rdata", RDATA, 32'hBEEF);
    BERR = 1'b1;
    for (int i = 0; i < 10 && BUSY; i++) cyc();
    check("be_release", BUSY, 0);

    // Reset while a write sits in WAIT.
    dtack_tie = 1'b1;
    REQ = 1'b1; WR = 1'b1; BE = 2'b11; WDATA = 16'hA5A5;
    cyc();
    REQ = 1'b0;
    cyc(); cyc(); cyc();
    check("rs_doe_pre", D_OE, 1);
    RESET = 1'b1;
    cyc();
    check("rs_as",   AS,   1);
    check("rs_uds",  UDS,  1);
    check("rs_lds",  LDS,  1);
    check("rs_doe",  D_OE, 0);
    check("rs_busy", BUSY, 0);
    check("rs_done", DONE, 0);
    RESET = 1'b0; dtack_tie = 1'b0;
    cyc();
    check("rs_done_after", DONE, 0);

    // REQ with no byte enables is ignored.
    REQ = 1'b1; WR = 1'b0; BE = 2'b00;
    idle_busy = 0; idle_as = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (BUSY) idle_busy = 1;
      if (!AS) idle_as = 1;
    end
    REQ = 1'b0;
    check("be0_busy", idle_busy, 0);
    check("be0_as",   idle_as,   0);

    // Back-to-back: REQ held high; second accept on edge 8, AS falls on edges 1 and 9.
    D_IN = 16'hCAFE;
    REQ = 1'b1; WR = 1'b0; BE = 2'b11;
    first_fall = -1; second_fall = -1; done1 = -1; done_cnt = 0;
    prev_as = AS;
    for (int i = 0; i <= 16; i++) begin
      cyc();
      if (prev_as && !AS) begin
        if (first_fall < 0) first_fall = i;
        else begin
          second_fall = i;
          REQ = 1'b0;
        end
      end
      if (DONE) begin
        if (done1 < 0) done1 = i;
        done_cnt++;
      end
      prev_as = AS;
    end
    check("b2b_fall1", first_fall,  1);
    check("b2b_done1", done1,       4);
    check("b2b_fall2", second_fall, 9);
    check("b2b_gap",   second_fall - done1, 5);
    check("b2b_ndone", done_cnt,    2);
    check("b2b_rdata", RDATA,       32'hCAFE);
    check("b2b_busy",  BUSY,        0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
